// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared types and helpers for the A-matrix multiply-pass sequencer.
// Fixed geometry: 4 columns x 4 RAM words per column, 16-word coefficient RAM.
package matmul_pkg;

   localparam int NUM_COL       = 4;
   localparam int WORDS_PER_COL = 4;
   localparam int ADDR_W        = 4;

   typedef logic [2:0] state_t;

   localparam state_t S_WAIT_A = 3'd0;
   localparam state_t S_IDLE   = 3'd1;
   localparam state_t S_ISSUE  = 3'd2;
   localparam state_t S_DRAIN  = 3'd3;
   localparam state_t S_OUT    = 3'd4;
   localparam state_t S_DONE   = 3'd5;

   // Column-major word address: each column occupies WORDS_PER_COL consecutive words.
   function automatic int addr_compose(input logic [1:0] col, input logic [1:0] k);
      return int'(col) * WORDS_PER_COL + int'(k);
   endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Sequencer-facing bundle: loader/start inputs, RAM read port, MAC controls, result handshake.
// master = sequencer side, slave = the surrounding datapath/sink.
interface matmul_seq_ctrl_if;
   import matmul_pkg::*;

   logic              aload_done;
   logic              start;
   logic              busy;
   logic              a_rd_en;
   logic [ADDR_W-1:0] a_rd_addr;
   logic              mac_en;
   logic              mac_clr;
   logic [1:0]        x_sel;
   logic              res_valid;
   logic [1:0]        res_col;
   logic              res_ready;
   logic              done;

   modport master (
      input  aload_done, start, res_ready,
      output busy, a_rd_en, a_rd_addr, mac_en, mac_clr, x_sel, res_valid, res_col, done
   );

   modport slave (
      output aload_done, start, res_ready,
      input  busy, a_rd_en, a_rd_addr, mac_en, mac_clr, x_sel, res_valid, res_col, done
   );
endinterface

// File: rtl/matmul_seq_ctrl_delay_pipe.sv
// Fixed-depth shift register that re-times issue-side MAC controls to RAM data arrival.
// Latency DEPTH cycles, no backpressure; clears to zero on reset.
module ctrl_delay_pipe #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_sr [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else begin
         r_sr[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Multiply-pass sequencer: per column, 4 RAM reads, RD_LAT drain, then result held until res_ready.
// Column takes WORDS_PER_COL+RD_LAT+1 cycles unstalled; res_ready low stalls in OUT indefinitely.
module matmul_seq_ctrl
   import matmul_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   matmul_seq_ctrl_if.master bus
);

   state_t     r_state;
   logic [1:0] r_col;
   logic [1:0] r_k;
   logic [1:0] r_dcnt;
   logic       r_aload_seen;

   logic       w_issue;
   logic [3:0] w_pipe_d;
   logic [3:0] w_pipe_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_WAIT_A;
         r_col        <= 2'd0;
         r_k          <= 2'd0;
         r_dcnt       <= 2'd0;
         r_aload_seen <= 1'b0;
      end else begin
         if (bus.aload_done) r_aload_seen <= 1'b1;
         case (r_state)
            S_WAIT_A: if (bus.aload_done || r_aload_seen) r_state <= S_IDLE;
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_ISSUE;
                  r_col   <= 2'd0;
                  r_k     <= 2'd0;
               end
            end
            S_ISSUE: begin
               if (r_k == 2'(WORDS_PER_COL - 1)) begin
                  r_k     <= 2'd0;
                  r_dcnt  <= 2'd0;
                  r_state <= S_DRAIN;
               end else begin
                  r_k <= r_k + 2'd1;
               end
            end
            S_DRAIN: begin
               if (r_dcnt == 2'(RD_LAT - 1)) r_state <= S_OUT;
               else                          r_dcnt  <= r_dcnt + 2'd1;
            end
            S_OUT: begin
               if (bus.res_ready) begin
                  if (r_col == 2'(NUM_COL - 1)) begin
                     r_state <= S_DONE;
                  end else begin
                     r_col   <= r_col + 2'd1;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_DONE: begin
               r_col   <= 2'd0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_WAIT_A;
         endcase
      end
   end

   assign w_issue = (r_state == S_ISSUE);

   // x_sel is forced to 0 outside ISSUE so idle MAC controls are all-zero.
   assign w_pipe_d = {w_issue, w_issue && (r_k == 2'd0), w_issue ? r_k : 2'd0};

   ctrl_delay_pipe #(
      .DEPTH (RD_LAT),
      .WIDTH (4)
   ) u_delay_pipe (
      .clk (clk),
      .rst (rst),
      .i_d (w_pipe_d),
      .o_q (w_pipe_q)
   );

   assign bus.mac_en    = w_pipe_q[3];
   assign bus.mac_clr   = w_pipe_q[2];
   assign bus.x_sel     = w_pipe_q[1:0];

   assign bus.a_rd_en   = w_issue;
   assign bus.a_rd_addr = w_issue ? ADDR_W'(addr_compose(r_col, r_k)) : '0;
   assign bus.res_valid = (r_state == S_OUT);
   assign bus.res_col   = (r_state == S_OUT) ? r_col : 2'd0;
   assign bus.done      = (r_state == S_DONE);
   assign bus.busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN) ||
                          (r_state == S_OUT)   || (r_state == S_DONE);

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Two sequencers (RD_LAT 1 and 3) share stimulus; a timeline model predicts every output each cycle.
module tb_matmul_seq_ctrl;
   import matmul_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic aload = 1'b0, start = 1'b0, ready = 1'b1;

   always #5 clk = ~clk;

   matmul_seq_ctrl_if if0();
   matmul_seq_ctrl_if if1();

   assign if0.aload_done = aload;
   assign if0.start      = start;
   assign if0.res_ready  = ready;
   assign if1.aload_done = aload;
   assign if1.start      = start;
   assign if1.res_ready  = ready;

   matmul_seq_ctrl #(.RD_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
   matmul_seq_ctrl #(.RD_LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

   int total = 0;
   int bad   = 0;
   int tb_cyc = 0;

   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, act, exp, tb_cyc);
      end
   endtask

   // Model: a pass is a list of columns; each column starts at cycle t0, reads for
   // WORDS_PER_COL cycles, sees data L cycles later, and offers its result from t0+WORDS_PER_COL+L.
   localparam int LAT [2] = '{1, 3};
   bit m_idle [2] = '{0, 0};
   bit m_pass [2] = '{0, 0};
   bit m_done [2] = '{0, 0};
   int m_col  [2] = '{0, 0};
   int m_t0   [2] = '{0, 0};

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            m_idle[d] <= 0; m_pass[d] <= 0; m_done[d] <= 0; m_col[d] <= 0; m_t0[d] <= 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (m_done[d]) begin
               m_pass[d] <= 0;
               m_done[d] <= 0;
            end else if (m_pass[d]) begin
               if (tb_cyc - m_t0[d] >= WORDS_PER_COL + LAT[d] && ready) begin
                  if (m_col[d] == NUM_COL - 1) m_done[d] <= 1;
                  else begin
                     m_col[d] <= m_col[d] + 1;
                     m_t0[d]  <= tb_cyc + 1;
                  end
               end
            end else if (m_idle[d]) begin
               if (start) begin
                  m_pass[d] <= 1; m_col[d] <= 0; m_t0[d] <= tb_cyc + 1;
               end
            end else if (aload) begin
               m_idle[d] <= 1;
            end
         end
      end
   end

   // Layout: busy rd_en addr[4] mac_en mac_clr x_sel[2] res_valid res_col[2] done
   function automatic logic [13:0] expv(input int d);
      logic [13:0] v;
      int rel, L;
      v   = '0;
      rel = tb_cyc - m_t0[d];
      L   = LAT[d];
      if (m_pass[d]) v[13] = 1'b1;
      if (m_done[d]) v[0] = 1'b1;
      else if (m_pass[d]) begin
         if (rel >= 0 && rel < WORDS_PER_COL) begin
            v[12]   = 1'b1;
            v[11:8] = 4'(m_col[d] * WORDS_PER_COL + rel);
         end
         if (rel >= L && rel < L + WORDS_PER_COL) begin
            v[7]   = 1'b1;
            v[6]   = (rel == L);
            v[5:4] = 2'(rel - L);
         end
         if (rel >= WORDS_PER_COL + L) begin
            v[3]   = 1'b1;
            v[2:1] = 2'(m_col[d]);
         end
      end
      return v;
   endfunction

   logic [13:0] obs0, obs1;
   assign obs0 = {if0.busy, if0.a_rd_en, if0.a_rd_addr, if0.mac_en, if0.mac_clr,
                  if0.x_sel, if0.res_valid, if0.res_col, if0.done};
   assign obs1 = {if1.busy, if1.a_rd_en, if1.a_rd_addr, if1.mac_en, if1.mac_clr,
                  if1.x_sel, if1.res_valid, if1.res_col, if1.done};

   always @(negedge clk) begin
      chk("outs_lat1", obs0, expv(0));
      chk("outs_lat3", obs1, expv(1));
   end

   int q_clr0[$], q_rv0[$], q_rvc0[$], q_done0[$], q_addr0[$];
   int q_men1[$], q_xs1[$], q_rv1[$], q_done1[$];
   logic pv0 = 1'b0, pv1 = 1'b0;

   always @(negedge clk) begin
      if (if0.mac_clr) q_clr0.push_back(tb_cyc);
      if (if0.res_valid && !pv0) begin
         q_rv0.push_back(tb_cyc);
         q_rvc0.push_back(int'(if0.res_col));
      end
      if (if0.done) q_done0.push_back(tb_cyc);
      if (if0.a_rd_en) q_addr0.push_back(int'(if0.a_rd_addr));
      if (if1.mac_en) begin
         q_men1.push_back(tb_cyc);
         q_xs1.push_back(int'(if1.x_sel));
      end
      if (if1.res_valid && !pv1) q_rv1.push_back(tb_cyc);
      if (if1.done) q_done1.push_back(tb_cyc);
      pv0 <= if0.res_valid;
      pv1 <= if1.res_valid;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clrq();
      q_clr0.delete(); q_rv0.delete(); q_rvc0.delete(); q_done0.delete(); q_addr0.delete();
      q_men1.delete(); q_xs1.delete(); q_rv1.delete(); q_done1.delete();
   endtask

   // Returns the index of the first cycle after the edge that sampled start.
   task automatic pulse_start(output int b);
      start = 1'b1;
      step(1);
      start = 1'b0;
      b = tb_cyc;
   endtask

   int base;
   int exp_clr0 [4] = '{1, 7, 13, 19};
   int exp_rv0  [4] = '{5, 11, 17, 23};

   initial begin
      #1 rst = 1'b0;
      step(2);
      rst = 1'b1;
      step(2);

      // Start before the loader finishes must be dropped.
      pulse_start(base);
      step(3);
      chk("t1_busy", {if0.busy, if1.busy}, 2'b00);
      chk("t1_rd",   {if0.a_rd_en, if1.a_rd_en}, 2'b00);
      aload = 1'b1; step(1);
      aload = 1'b0; step(2);

      // Unstalled pass: pin the model against hand-derived timing.
      clrq();
      pulse_start(base);
      step(40);
      chk("t2_nclr0", q_clr0.size(), 4);
      for (int i = 0; i < 4; i++) if (i < q_clr0.size()) chk("t2_clr0", q_clr0[i] - base, exp_clr0[i]);
      chk("t2_nrv0", q_rv0.size(), 4);
      for (int i = 0; i < 4; i++) if (i < q_rv0.size()) begin
         chk("t2_rv0", q_rv0[i] - base, exp_rv0[i]);
         chk("t2_rvcol0", q_rvc0[i], i);
      end
      chk("t2_ndone0", q_done0.size(), 1);
      if (q_done0.size() > 0) chk("t2_done0", q_done0[0] - base, 24);
      chk("t2_naddr0", q_addr0.size(), 16);
      for (int i = 0; i < 16; i++) if (i < q_addr0.size()) chk("t2_addr0", q_addr0[i], i);
      chk("t2_nmen1", q_men1.size(), 16);
      if (q_men1.size() > 0) chk("t2_men1", q_men1[0] - base, 3);
      for (int i = 0; i < 4; i++) if (i < q_xs1.size()) chk("t2_xs1", q_xs1[i], i);
      if (q_rv1.size() > 0) chk("t2_rv1", q_rv1[0] - base, 7);
      else chk("t2_nrv1", q_rv1.size(), 4);
      chk("t2_ndone1", q_done1.size(), 1);
      if (q_done1.size() > 0) chk("t2_done1", q_done1[0] - base, 32);

      // Stall on column 1.
      clrq();
      ready = 1'b0;
      pulse_start(base);
      for (int i = 0; i < 60 && !if1.res_valid; i++) step(1);
      chk("t3_wait_col0", if1.res_valid, 1'b1);
      ready = 1'b1; step(1);
      ready = 1'b0;
      for (int i = 0; i < 60 && !if1.res_valid; i++) step(1);
      chk("t3_wait_col1", if1.res_valid, 1'b1);
      step(5);
      chk("t3_hold0", {if0.res_valid, if0.res_col, if0.a_rd_en}, 4'b1_01_0);
      chk("t3_hold1", {if1.res_valid, if1.res_col, if1.a_rd_en}, 4'b1_01_0);
      ready = 1'b1; step(1);
      chk("t3_col2rd0", {if0.a_rd_en, if0.a_rd_addr}, {1'b1, 4'd8});
      chk("t3_col2rd1", {if1.a_rd_en, if1.a_rd_addr}, {1'b1, 4'd8});
      step(50);
      chk("t3_ndone", {q_done0.size(), q_done1.size()}, {32'd1, 32'd1});

      // Repeated start while busy.
      clrq();
      pulse_start(base);
      for (int i = 0; i < 10; i++) begin
         start = 1'b1; step(1);
         start = 1'b0; step(1);
      end
      step(30);
      chk("t5_ndone0", q_done0.size(), 1);
      chk("t5_ndone1", q_done1.size(), 1);

      // Reset in the middle of column 2 reads.
      pulse_start(base);
      for (int i = 0; i < 60 && !(if0.a_rd_en && if0.a_rd_addr == 4'd8); i++) step(1);
      chk("t5_reach_col2", {if0.a_rd_en, if0.a_rd_addr}, {1'b1, 4'd8});
      step(1);
      rst = 1'b0;
      #1;
      chk("t5_rst0", obs0, 14'd0);
      chk("t5_rst1", obs1, 14'd0);
      step(2);
      rst = 1'b1;
      clrq();
      step(30);
      chk("t5_nodone", q_done0.size() + q_done1.size(), 0);
      pulse_start(base);
      step(3);
      chk("t5_wait_a", {if0.busy, if1.busy, if0.a_rd_en, if1.a_rd_en}, 4'b0000);
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
